// File: rtl/led_pattern_ctrl_if.sv
// rtl/led_pattern_ctrl_if.sv - register bus bundle for led_pattern_ctrl
//   we   : write strobe, one cycle per write
//   addr : word index 0=DATA 1=CTRL 2=PERIOD 3=STATUS
//   wd   : write data
//   rd   : read data for addr, combinational from registers
interface led_pattern_ctrl_if;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, addr, wd, input rd);
  modport slave  (input we, addr, wd, output rd);
endinterface

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - LED bank sequencer with static/blink/rotate modes
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave register port (we/addr/wd/rd)
//   LED_data   : drive to LED bank
//   tick       : one-cycle pulse in the cycle a pattern step is taken
module led_pattern_ctrl #(
  parameter int              LED_W      = 8,
  parameter int              CNT_W      = 24,
  parameter logic [CNT_W-1:0] PERIOD_RST = 24'd5_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  led_pattern_ctrl_if.slave  bus,
  output logic [LED_W-1:0]   LED_data,
  output logic               tick
);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTL   = 2'd2,
    MODE_ROTR   = 2'd3
  } mode_e;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_CTRL   = 2'd1;
  localparam logic [1:0] A_PERIOD = 2'd2;

  logic [LED_W-1:0] pattern_q, pattern_d;
  logic [LED_W-1:0] disp_q, disp_d;
  mode_e            mode_q, mode_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_on_q, blink_on_d;
  logic [15:0]      steps_q, steps_d;

  logic [CNT_W-1:0] peff_m1;
  logic             step;
  logic [7:0]       disp8;
  logic             unused_wd;

  assign unused_wd = ^bus.wd;

  // STATUS always shows an 8-bit display field regardless of bank width
  generate
    if (LED_W >= 8) begin : g_disp_wide
      assign disp8 = disp_q[7:0];
    end else begin : g_disp_narrow
      assign disp8 = {{(8-LED_W){1'b0}}, disp_q};
    end
  endgenerate

  always_comb begin
    pattern_d  = pattern_q;
    disp_d     = disp_q;
    mode_d     = mode_q;
    en_d       = en_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    blink_on_d = blink_on_q;
    steps_d    = steps_q;

    // A period of zero is treated as one so the prescaler never stalls
    peff_m1 = (period_q == '0) ? '0 : period_q - 1'b1;
    // Any bus write in the same cycle suppresses the step
    step    = en_q && !bus.we && (cnt_q == peff_m1);

    if (!en_q) begin
      cnt_d = '0;
    end else if (!bus.we) begin
      cnt_d = step ? '0 : cnt_q + 1'b1;
    end

    if (step) begin
      steps_d = steps_q + 16'd1;
      case (mode_q)
        MODE_BLINK: blink_on_d = ~blink_on_q;
        MODE_ROTL:  disp_d = {disp_q[LED_W-2:0], disp_q[LED_W-1]};
        MODE_ROTR:  disp_d = {disp_q[0], disp_q[LED_W-1:1]};
        default:    ;
      endcase
    end

    if (bus.we) begin
      case (bus.addr)
        A_DATA: begin
          pattern_d  = bus.wd[LED_W-1:0];
          disp_d     = bus.wd[LED_W-1:0];
          blink_on_d = 1'b1;
          cnt_d      = '0;
        end
        A_CTRL: begin
          mode_d     = mode_e'(bus.wd[1:0]);
          en_d       = bus.wd[2];
          disp_d     = pattern_q;
          blink_on_d = 1'b1;
          cnt_d      = '0;
          steps_d    = '0;
        end
        A_PERIOD: begin
          period_d = bus.wd[CNT_W-1:0];
          cnt_d    = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q  <= '1;
      disp_q     <= '1;
      mode_q     <= MODE_STATIC;
      en_q       <= 1'b0;
      period_q   <= PERIOD_RST;
      cnt_q      <= '0;
      blink_on_q <= 1'b1;
      steps_q    <= '0;
    end else begin
      pattern_q  <= pattern_d;
      disp_q     <= disp_d;
      mode_q     <= mode_d;
      en_q       <= en_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      blink_on_q <= blink_on_d;
      steps_q    <= steps_d;
    end
  end

  assign tick     = step;
  assign LED_data = (mode_q == MODE_BLINK && !blink_on_q) ? '0 : disp_q;

  always_comb begin
    bus.rd = '0;
    case (bus.addr)
      2'd0:    bus.rd = 32'(pattern_q);
      2'd1:    bus.rd = {29'b0, en_q, mode_q};
      2'd2:    bus.rd = 32'(period_q);
      default: bus.rd = {steps_q, 7'b0, blink_on_q, disp8};
    endcase
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - self-checking bench for led_pattern_ctrl
module tb_led_pattern_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] led;
  logic       tick;
  int         n_assert = 0;
  int         n_fail = 0;
  bit         do_chk = 1'b1;

  led_pattern_ctrl_if bus ();

  led_pattern_ctrl #(
    .LED_W(8), .CNT_W(24), .PERIOD_RST(24'd5_000_000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .LED_data(led), .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference model: the display is derived from the pattern and the number
  // of steps taken since it was last reloaded; ticks fall every peff-th
  // enabled, write-free cycle since the prescaler was last cleared.
  bit [7:0]    m_pattern;
  bit [1:0]    m_mode;
  bit          m_en;
  bit [23:0]   m_period;
  int unsigned m_c;
  int unsigned m_k;
  bit [15:0]   m_steps;

  function automatic void m_reset();
    m_pattern = 8'hFF; m_mode = 2'd0; m_en = 1'b0; m_period = 24'd5_000_000;
    m_c = 0; m_k = 0; m_steps = 16'd0;
  endfunction

  function automatic bit [7:0] m_disp();
    bit [7:0] v;
    v = m_pattern;
    for (int i = 0; i < int'(m_k % 8); i++) begin
      if (m_mode == 2'd2) v = {v[6:0], v[7]};
      else if (m_mode == 2'd3) v = {v[0], v[7:1]};
    end
    return v;
  endfunction

  function automatic bit m_blink();
    return !(m_mode == 2'd1 && (m_k % 2) == 1);
  endfunction

  function automatic bit [7:0] m_led();
    return m_blink() ? m_disp() : 8'h00;
  endfunction

  function automatic bit m_tick(input bit w);
    int unsigned peff;
    peff = (m_period == 0) ? 1 : int'(m_period);
    return m_en && !w && ((m_c + 1) % peff == 0);
  endfunction

  function automatic bit [31:0] m_rd(input bit [1:0] a);
    case (a)
      2'd0:    return {24'b0, m_pattern};
      2'd1:    return {29'b0, m_en, m_mode};
      2'd2:    return {8'b0, m_period};
      default: return {m_steps, 7'b0, m_blink(), m_disp()};
    endcase
  endfunction

  function automatic void m_update(input bit w, input bit [1:0] a, input bit [31:0] d);
    if (m_tick(w)) begin
      m_k++;
      m_steps = m_steps + 16'd1;
    end
    if (m_en && !w) m_c++;
    if (w) begin
      case (a)
        2'd0: begin m_pattern = d[7:0]; m_k = 0; m_c = 0; end
        2'd1: begin m_mode = d[1:0]; m_en = d[2]; m_k = 0; m_c = 0; m_steps = 16'd0; end
        2'd2: begin m_period = d[23:0]; m_c = 0; end
        default: ;
      endcase
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, sample at the falling edge, advance the model.
  task automatic step(input bit w, input bit [1:0] a, input bit [31:0] d,
                      output logic [7:0] led_seen, output logic tick_seen);
    bus.we = w; bus.addr = a; bus.wd = d;
    @(negedge clk);
    led_seen = led;
    tick_seen = tick;
    if (do_chk) begin
      chk("tick", {31'b0, tick}, {31'b0, m_tick(w)});
      chk("led", {24'b0, led}, {24'b0, m_led()});
      chk("rd", bus.rd, m_rd(a));
    end
    m_update(w, a, d);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] ls;
  logic       ts;
  logic [7:0] blink_seq [6] = '{8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h0F};
  logic [7:0] rotl_seq  [5] = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18};
  logic [7:0] rotr_seq  [4] = '{8'h81, 8'hC0, 8'h60, 8'h30};

  initial begin
    bus.we = 1'b0; bus.addr = 2'd0; bus.wd = 32'd0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_led", {24'b0, led}, 32'h0000_00FF);
    chk("rst_tick", {31'b0, tick}, 32'd0);
    bus.addr = 2'd0; #1 chk("rst_rd0", bus.rd, 32'h0000_00FF);
    bus.addr = 2'd1; #1 chk("rst_rd1", bus.rd, 32'h0000_0000);
    bus.addr = 2'd2; #1 chk("rst_rd2", bus.rd, 32'h004C_4B40);
    bus.addr = 2'd3; #1 chk("rst_rd3", bus.rd, 32'h0000_01FF);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Static
    step(1, 2'd0, 32'h5A, ls, ts);
    step(1, 2'd1, 32'h4, ls, ts);
    step(1, 2'd2, 32'd3, ls, ts);
    for (int i = 0; i < 9; i++) begin
      step(0, 2'd3, 0, ls, ts);
      chk("static_led", {24'b0, ls}, 32'h5A);
      chk("static_tick", {31'b0, ts}, {31'b0, (i % 3) == 2});
    end

    // Blink
    step(1, 2'd2, 32'd2, ls, ts);
    step(1, 2'd0, 32'h0F, ls, ts);
    step(1, 2'd1, 32'h5, ls, ts);
    for (int i = 0; i < 6; i++) begin
      step(0, 2'd3, 0, ls, ts);
      chk("blink_seq", {24'b0, ls}, {24'b0, blink_seq[i]});
    end

    // Rotate left then right
    step(1, 2'd2, 32'd1, ls, ts);
    step(1, 2'd0, 32'h81, ls, ts);
    step(1, 2'd1, 32'h6, ls, ts);
    for (int i = 0; i < 5; i++) begin
      step(0, 2'd3, 0, ls, ts);
      chk("rotl_seq", {24'b0, ls}, {24'b0, rotl_seq[i]});
    end
    step(1, 2'd1, 32'h7, ls, ts);
    for (int i = 0; i < 4; i++) begin
      step(0, 2'd3, 0, ls, ts);
      chk("rotr_seq", {24'b0, ls}, {24'b0, rotr_seq[i]});
    end

    // Period 0 behaves as 1
    step(1, 2'd2, 32'd0, ls, ts);
    step(1, 2'd1, 32'h4, ls, ts);
    for (int i = 0; i < 4; i++) begin
      step(0, 2'd2, 0, ls, ts);
      chk("p0_tick", {31'b0, ts}, 32'd1);
    end

    // Write on the step cycle wins
    step(1, 2'd2, 32'd3, ls, ts);
    step(1, 2'd1, 32'h4, ls, ts);
    step(0, 2'd0, 0, ls, ts);
    step(0, 2'd0, 0, ls, ts);
    step(1, 2'd0, 32'h33, ls, ts);
    chk("coll_tick", {31'b0, ts}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 2'd3, 0, ls, ts);
      chk("coll_led", {24'b0, ls}, 32'h33);
      chk("coll_restart", {31'b0, ts}, {31'b0, i == 2});
    end

    // Random traffic
    step(1, 2'd2, 32'd2, ls, ts);
    step(1, 2'd1, 32'h6, ls, ts);
    for (int i = 0; i < 400; i++) begin
      bit        w;
      bit [1:0]  a;
      bit [31:0] d;
      w = ($urandom_range(0, 4) == 0);
      a = 2'($urandom_range(0, 3));
      case (a)
        2'd1:    d = 32'($urandom_range(0, 7)) | 32'h4;
        2'd2:    d = 32'($urandom_range(0, 4));
        default: d = $urandom;
      endcase
      step(w, a, d, ls, ts);
    end

    // Asynchronous reset mid-rotation
    step(1, 2'd2, 32'd1, ls, ts);
    step(1, 2'd0, 32'h81, ls, ts);
    step(1, 2'd1, 32'h6, ls, ts);
    repeat (3) step(0, 2'd3, 0, ls, ts);
    bus.we = 1'b0; bus.addr = 2'd1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_led", {24'b0, led}, 32'h0000_00FF);
    chk("mid_rst_tick", {31'b0, tick}, 32'd0);
    chk("mid_rst_rd1", bus.rd, 32'd0);
    bus.addr = 2'd2; #1 chk("mid_rst_rd2", bus.rd, 32'h004C_4B40);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    @(posedge clk); #1;
    step(0, 2'd3, 0, ls, ts);
    chk("post_rst_led", {24'b0, ls}, 32'hFF);

    // Step counter wrap
    step(1, 2'd2, 32'd1, ls, ts);
    step(1, 2'd1, 32'h4, ls, ts);
    do_chk = 1'b0;
    for (int i = 0; i < 65536; i++) step(0, 2'd3, 0, ls, ts);
    do_chk = 1'b1;
    bus.we = 1'b0; bus.addr = 2'd3;
    @(negedge clk);
    chk("wrap_steps", {16'b0, bus.rd[31:16]}, 32'd0);
    chk("wrap_model", {16'b0, bus.rd[31:16]}, {16'b0, m_steps});
    @(posedge clk); #1;
    m_update(1'b0, 2'd3, 32'd0);

    // Disable
    step(1, 2'd1, 32'h2, ls, ts);
    for (int i = 0; i < 5; i++) begin
      step(0, 2'd3, 0, ls, ts);
      chk("dis_tick", {31'b0, ts}, 32'd0);
      chk("dis_led", {24'b0, ls}, 32'hFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
